// File: rtl/param_dist_ram.sv
// Simple-dual-port distributed RAM with byte enables, selectable read-during-write
// behaviour, optional output register and a clear engine that fills the array with CLEAR_VAL.
module param_dist_ram #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DEPTH     = 256,
  parameter int unsigned       RDW_MODE  = 0,
  parameter int unsigned       OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int                BE_W     = int'(DATA_W / 8);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   rd_data1_q, rd_data1_d;
  logic                rd_valid1_q, rd_valid1_d;
  logic [DATA_W-1:0]   rd_data2_q, rd_data2_d;
  logic                rd_valid2_q, rd_valid2_d;
  logic                wr_ok, rd_acc;
  logic [DATA_W-1:0]   rd_word;

  (* ram_style = "distributed" *) logic [DATA_W-1:0] mem_q [DEPTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs of the FSM: busy gates both ports
  always_comb begin
    busy   = (state_q == S_CLEAR);
    wr_ok  = !busy && wr_en && ({1'b0, wr_addr} < DEPTH_C);
    rd_acc = !busy && rd_en;
  end

  // Clear engine owns the write port while busy
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[ptr_q] <= CLEAR_VAL;
    end else if (wr_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Write-first mode forwards the enabled bytes of a same-address write
  always_comb begin
    rd_word = '0;
    if ({1'b0, rd_addr} < DEPTH_C) begin
      rd_word = mem_q[rd_addr];
      if (RDW_MODE == 1 && wr_ok && wr_addr == rd_addr) begin
        for (int i = 0; i < BE_W; i++) begin
          if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_data1_d  = rd_acc ? rd_word : rd_data1_q;
    rd_valid1_d = rd_acc;
    rd_data2_d  = rd_valid1_q ? rd_data1_q : rd_data2_q;
    rd_valid2_d = rd_valid1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1_q  <= '0;
      rd_valid1_q <= 1'b0;
      rd_data2_q  <= '0;
      rd_valid2_q <= 1'b0;
    end else begin
      rd_data1_q  <= rd_data1_d;
      rd_valid1_q <= rd_valid1_d;
      rd_data2_q  <= rd_data2_d;
      rd_valid2_q <= rd_valid2_d;
    end
  end

  assign rd_data  = (OUT_REG == 1) ? rd_data2_q  : rd_data1_q;
  assign rd_valid = (OUT_REG == 1) ? rd_valid2_q : rd_valid1_q;

endmodule

// File: tb/tb_param_dist_ram.sv
// Two configurations driven with shared stimulus: A (256 words, read-first, latency 1, clear to 0)
// and B (200 words, write-first, latency 2, clear to A5A55A5A), both checked against a behavioural model.
module tb_param_dist_ram;

  localparam logic [31:0] CV_B = 32'hA5A5_5A5A;

  logic        clk, rst_n, clr_req, wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        busy_a, busy_b, rd_valid_a, rd_valid_b;
  logic [31:0] rd_data_a, rd_data_b;

  int n_checks = 0;
  int n_pass   = 0;

  param_dist_ram #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RDW_MODE(0), .OUT_REG(0),
                   .CLEAR_VAL(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

  param_dist_ram #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RDW_MODE(1), .OUT_REG(1),
                   .CLEAR_VAL(CV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm [2][256];
  int          clr_left [2] = '{256, 200};
  logic [31:0] exp_data [2] = '{32'h0, 32'h0};
  logic        exp_valid[2] = '{1'b0, 1'b0};
  logic [31:0] pend_data[2] = '{32'h0, 32'h0};
  logic        pend_valid[2] = '{1'b0, 1'b0};

  function automatic int dep(input int i);
    return (i == 0) ? 256 : 200;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] nw);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic model_step(input int i);
    logic        is_busy, acc, wok;
    logic [31:0] val;
    if (!rst_n) begin
      clr_left[i] = dep(i);
      exp_data[i] = '0;  exp_valid[i] = 1'b0;
      pend_data[i] = '0; pend_valid[i] = 1'b0;
    end else begin
      is_busy = clr_left[i] > 0;
      acc = !is_busy && rd_en;
      wok = !is_busy && wr_en && (int'(wr_addr) < dep(i));
      val = '0;
      if (int'(rd_addr) < dep(i)) begin
        val = mm[i][rd_addr];
        if (i == 1 && wok && wr_addr == rd_addr) val = merge(val, wr_be, wr_data);
      end
      if (is_busy) begin
        mm[i][dep(i) - clr_left[i]] = (i == 0) ? 32'h0 : CV_B;
        clr_left[i]--;
      end else begin
        if (wok) mm[i][wr_addr] = merge(mm[i][wr_addr], wr_be, wr_data);
        if (clr_req) clr_left[i] = dep(i);
      end
      if (i == 1) begin
        exp_valid[i] = pend_valid[i];
        if (pend_valid[i]) exp_data[i] = pend_data[i];
        pend_valid[i] = acc;
        if (acc) pend_data[i] = val;
      end else begin
        exp_valid[i] = acc;
        if (acc) exp_data[i] = val;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    chk("busy_a",  {31'b0, busy_a},     {31'b0, clr_left[0] > 0});
    chk("valid_a", {31'b0, rd_valid_a}, {31'b0, exp_valid[0]});
    chk("data_a",  rd_data_a,           exp_data[0]);
    chk("busy_b",  {31'b0, busy_b},     {31'b0, clr_left[1] > 0});
    chk("valid_b", {31'b0, rd_valid_b}, {31'b0, exp_valid[1]});
    chk("data_b",  rd_data_b,           exp_data[1]);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic rd(input logic [7:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  // Counts busy samples from now (inclusive) until both instances are idle.
  task automatic count_busy(output int na, output int nb, input bit try_write);
    na = 0; nb = 0;
    for (int k = 0; k < 600; k++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      if (!busy_a && !busy_b) break;
      if (try_write && k == 0) wr(8'h03, 32'hCAFE_F00D, 4'hF);
      tick();
      wr_en = 1'b0;
    end
  endtask

  initial begin
    int na, nb;
    rst_n = 1'b0; wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
    idle_in();
    repeat (3) tick();
    rst_n = 1'b1;
    count_busy(na, nb, 1'b0);
    chk("rst_busy_len_a", na, 256);
    chk("rst_busy_len_b", nb, 200);

    rd(8'h7F); tick(); idle_in();
    chk("t1_valid_a", {31'b0, rd_valid_a}, 1);
    chk("t1_data_a", rd_data_a, 32'h0);
    chk("t1_b_not_yet", {31'b0, rd_valid_b}, 0);
    tick();
    chk("t1_data_b", rd_data_b, CV_B);

    wr(8'h10, 32'hDEAD_BEEF, 4'hF); tick();
    wr(8'h10, 32'h1122_3344, 4'b0101); tick(); idle_in();
    rd(8'h10); tick(); idle_in();
    chk("t2_merge_a", rd_data_a, 32'hDE22_BE44);
    tick();
    chk("t2_merge_b", rd_data_b, 32'hDE22_BE44);

    wr(8'h05, 32'hAAAA_AAAA, 4'hF); tick();
    wr(8'h05, 32'h5555_5555, 4'hF); rd(8'h05); tick(); idle_in();
    chk("t3_read_first_a", rd_data_a, 32'hAAAA_AAAA);
    tick();
    chk("t3_write_first_b", rd_data_b, 32'h5555_5555);

    for (int k = 0; k < 3; k++) begin
      wr(8'(k), 32'h100 + 32'(k), 4'hF); tick();
    end
    idle_in();
    rd(8'h00); tick();
    chk("t4_c1_valid_b", {31'b0, rd_valid_b}, 0);
    rd(8'h01); tick();
    chk("t4_c2_data_b", rd_data_b, 32'h100);
    rd(8'h02); tick(); idle_in();
    chk("t4_c3_data_b", rd_data_b, 32'h101);
    tick();
    chk("t4_c4_data_b", rd_data_b, 32'h102);
    chk("t4_c4_valid_b", {31'b0, rd_valid_b}, 1);
    tick();
    chk("t4_c5_valid_b", {31'b0, rd_valid_b}, 0);

    wr(8'hF0, 32'h1234_5678, 4'hF); tick(); idle_in();
    rd(8'hF0); tick(); idle_in();
    chk("t6_in_range_a", rd_data_a, 32'h1234_5678);
    tick();
    chk("t6_oob_valid_b", {31'b0, rd_valid_b}, 1);
    chk("t6_oob_data_b", rd_data_b, 32'h0);

    clr_req = 1'b1; tick(); clr_req = 1'b0;
    count_busy(na, nb, 1'b1);
    chk("t5_busy_len_a", na, 256);
    chk("t5_busy_len_b", nb, 200);
    rd(8'h03); tick(); idle_in();
    chk("t5_dropped_a", rd_data_a, 32'h0);
    tick();
    chk("t5_cleared_b", rd_data_b, CV_B);

    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    count_busy(na, nb, 1'b0);
    chk("t6_restart_len_a", na, 256);
    chk("t6_restart_len_b", nb, 200);

    for (int c = 0; c < 3000; c++) begin
      clr_req = ($urandom_range(0, 149) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      wr_be   = 4'($urandom);
      wr_data = $urandom;
      rd_en   = $urandom_range(0, 1);
      rd_addr = ($urandom_range(0, 9) < 3) ? wr_addr
              : (($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom));
      tick();
    end
    idle_in();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
